div_hilo_ctrl: RTL
==================

// Module: div_hilo_ctrl
// PURPOSE
//   EX-stage initiator for the 33-cycle sequential divider: issues DIV/DIVU, stalls the pipe until
//   the divider reports complete, commits Q->LO and R->HI, and owns the HI/LO registers.
//   Handles MTHI/MTLO and exports HI/LO for MFHI/MFLO. The divider is a peer instance in the EX stage.
//   This block drives its resetn/div/isSigned/A/B and consumes its Q/R/complete.
// PARAMETERS
//   DW       32  operand / HI / LO width
// PORTS
//   clk         in   1   clock, rising edge
//   resetn      in   1   asynchronous, active-low reset
//   ex_valid    in   1   valid instruction in EX
//   ex_op       in   3   0 NOP, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, others = NOP
//   ex_rs       in   DW  rs operand (dividend / MT source)
//   ex_rt       in   DW  rt operand (divisor)
//   flush       in   1   exception flush of EX; cancels an uncommitted divide
//   ex_stall    out  1   hold IF/ID/EX this cycle
//   busy        out  1   divide in flight (state != IDLE)
//   hi_out      out  DW  HI register
//   lo_out      out  DW  LO register
//   div_rstn    out  1   divider sync clear, active-low; high only while RUN
//   div_go      out  1   divider "div" enable
//   div_signed  out  1   divider isSigned
//   div_a       out  DW  dividend, stable throughout RUN
//   div_b       out  DW  divisor, stable throughout RUN
//   div_q       in   DW  quotient, valid when div_done
//   div_r       in   DW  remainder, valid when div_done
//   div_done    in   1   divider complete; level, stays high until div_rstn low
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE; hi/lo=0; op_a/op_b/op_sgn=0.
//     Outputs then: div_rstn=0, div_go=0, busy=0, ex_stall=0.
//   States: IDLE, RUN, DONE (2-bit register). div_rstn = div_go = (state==RUN).
//     busy = (state!=IDLE).
//   issue = ex_valid & (ex_op==DIV | ex_op==DIVU) & ~flush.
//   IDLE:
//     - issue: latch op_a=ex_rs, op_b=ex_rt, op_sgn=(ex_op==DIV); go to RUN.
//     - ex_valid & MTHI & ~flush: hi<=ex_rs. MTLO likewise writes lo. No stall.
//   RUN:
//     - Drive div_a/div_b/div_signed from latches.
//     - div_done & ~flush: lo<=div_q, hi<=div_r; go to DONE.
//     - flush (any cycle, including coincident with div_done): go to IDLE, no HI/LO write.
//   DONE: one cycle, stall released so the DIV retires exactly once; no issue accepted; go to IDLE.
//     Flush here does not undo the already-committed HI/LO.
//   ex_stall = (state==IDLE & issue) | (state==RUN). It is combinational from inputs in IDLE.
//   Latency with a 33-cycle divider:
//     - issue cycle T0: stall=1.
//     - RUN T1..T34: divider counter 0..33; done seen at T34.
//     - DONE T35: stall=0, hi_out/lo_out already new.
//     - Total stall = 35 cycles.
//   div_rstn is low in IDLE and DONE, so the divider is cleared at least one cycle before every
//     issue. Back-to-back DIVs: the second issues the cycle after DONE.
//   MTHI/MTLO never coincide with RUN: EX is held. They are ignored outside IDLE.
//   Divide-by-zero and 0x80000000/-1: commit whatever the divider returns. No trap, no extra cycles.
//   hi_out/lo_out are register outputs; MFHI in the cycle after MTHI/DONE sees the new value.
//   Width: all datapaths are DW bits; no extension or truncation in this block.
// STRUCTURE
//   Shared package: ex_op encodings (OP_NOP..OP_MTLO), state encodings (ST_IDLE/ST_RUN/ST_DONE).
//   No sub-module: one FSM plus HI/LO/operand registers. The divider is instantiated beside this
//     block in the EX stage.
// TESTING (behavioural divider model, done 33 cycles after first div_go with counter cleared)
//   1. DIVU rs=100 rt=7:
//      - ex_stall high exactly 35 cycles; div_go high 34 cycles.
//      - Then lo_out=14, hi_out=2.
//   2. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF, div_signed=1 during RUN.
//   3. DIV issued, flush at RUN cycle 10:
//      - Next cycle state=IDLE, div_rstn=0, ex_stall=0.
//      - hi/lo unchanged.
//   4. MTHI 0x1234 then MTLO 0xABCD on consecutive cycles:
//      - hi_out=0x1234 and lo_out=0xABCD one cycle after each.
//      - ex_stall never asserted.
//   5. Two DIVU back-to-back (8/3 then 9/4):
//      - div_rstn low in DONE of the first.
//      - Final lo_out=2, hi_out=1.
//      - Total stall 70 cycles.
//   6. resetn low at RUN cycle 20:
//      - Immediately div_go=0, ex_stall=0, hi/lo=0.
//      - After release, a fresh DIVU 10/3 gives lo_out=3, hi_out=1.

Source files
------------

// File: rtl/div_hilo_ctrl_pkg.sv
// Shared encodings for the EX-stage divide initiator.
// Used by div_hilo_ctrl and its bench.
package div_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_hilo_ctrl.sv
// EX-stage divide initiator: issues DIV/DIVU to the peer divider,
// stalls until complete, commits Q->LO / R->HI, owns HI/LO.
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ex_valid,
  input  logic [2:0]    ex_op,
  input  logic [DW-1:0] ex_rs,
  input  logic [DW-1:0] ex_rt,
  input  logic          flush,
  output logic          ex_stall,
  output logic          busy,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out,
  output logic          div_rstn,
  output logic          div_go,
  output logic          div_signed,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  input  logic [DW-1:0] div_q,
  input  logic [DW-1:0] div_r,
  input  logic          div_done
);

  state_e        state_q, state_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] op_a_q, op_b_q;
  logic          op_sgn_q;

  logic is_div, is_divu, is_mthi, is_mtlo;
  logic in_idle, in_run;
  logic issue, commit;

  always_comb begin
    is_div  = 1'b0;
    is_divu = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (ex_op == OP_DIV):  is_div  = ex_valid;
      (ex_op == OP_DIVU): is_divu = ex_valid;
      (ex_op == OP_MTHI): is_mthi = ex_valid;
      (ex_op == OP_MTLO): is_mtlo = ex_valid;
      default: ;
    endcase
  end

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);
  assign issue   = (is_div | is_divu) & ~flush;
  assign commit  = in_run & div_done & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (issue) state_d = ST_RUN;
      ST_RUN: begin
        // flush wins even when it lands on the done cycle
        if (flush)         state_d = ST_IDLE;
        else if (div_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      lo_d = div_q;
      hi_d = div_r;
    end else if (in_idle & ~flush) begin
      if (is_mthi) hi_d = ex_rs;
      if (is_mtlo) lo_d = ex_rs;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sgn_q <= 1'b0;
    end else if (in_idle & issue) begin
      op_a_q   <= ex_rs;
      op_b_q   <= ex_rt;
      op_sgn_q <= is_div;
    end
  end

  // divider is held in clear whenever it is not running
  assign div_rstn   = in_run;
  assign div_go     = in_run;
  assign div_signed = op_sgn_q;
  assign div_a      = op_a_q;
  assign div_b      = op_b_q;

  assign busy     = ~in_idle;
  assign ex_stall = (in_idle & issue) | in_run;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
